// File: rtl/logic_result_queue.sv
// Bitwise logic stage (AND/OR/XOR/NOR per lane) feeding a registered result FIFO.
// Optional pop counter (ops_done/ops_clr) built only when LOGIC_OPCOUNT_EN is defined.
module logic_result_queue #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               o,
  output logic                       zero,
  output logic [1:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count
`ifdef LOGIC_OPCOUNT_EN
  ,
  input  logic                       ops_clr,
  output logic [7:0]                 ops_done
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = W + 3;

  // Handshakes: a transfer happens on a rising edge only when valid and ready
  // are both high; ready never depends on valid on either side.
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [W-1:0]  result;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    result = '0;
    case (op)
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = a ^ b;
      default: result = ~(a | b);
    endcase
  end

  // Head is read straight from storage, so clearing storage on reset zeroes o/zero/out_op.
  assign {out_op, zero, o} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {op, ~|result, result};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef LOGIC_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst || ops_clr) ops_done <= '0;
    else if (pop && ops_done != 8'hFF) ops_done <= ops_done + 8'd1;
  end
`endif

endmodule

// File: tb/tb_logic_result_queue.sv
// Randomized and directed bench for logic_result_queue against a queue-based model.
module tb_logic_result_queue;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] r;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  o;
  logic          zero;
  logic [1:0]    out_op;
  logic [CW-1:0] count;
`ifdef LOGIC_OPCOUNT_EN
  logic          ops_clr;
  logic [7:0]    ops_done;
  int            exp_ops;
`endif

  entry_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  logic_result_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .zero(zero), .out_op(out_op), .count(count)
`ifdef LOGIC_OPCOUNT_EN
    , .ops_clr(ops_clr), .ops_done(ops_done)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [1:0] f, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (f)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every visible output against the model
  task automatic check_all();
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    if (exp_q.size() != 0) begin
      chk("o", 32'(o), 32'(exp_q[0].r));
      chk("zero", 32'(zero), 32'(exp_q[0].r == '0));
      chk("out_op", 32'(out_op), 32'(exp_q[0].op));
    end
`ifdef LOGIC_OPCOUNT_EN
    chk("ops_done", 32'(ops_done), 32'(exp_ops));
`endif
  endtask

  // driver: one clock with the given inputs, then update model and check
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [1:0] iop, input logic ordy, input logic clr = 1'b0);
    bit do_push, do_pop;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
`ifdef LOGIC_OPCOUNT_EN
    ops_clr = clr;
`endif
    do_push = iv && (exp_q.size() < DEPTH);
    do_pop  = ordy && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back('{op: iop, r: ref_op(iop, ia, ib)});
`ifdef LOGIC_OPCOUNT_EN
    if (clr) exp_ops = 0;
    else if (do_pop && exp_ops < 255) exp_ops++;
`endif
    check_all();
  endtask

  task automatic do_reset(input logic iv, input logic ordy);
    rst       = 1'b1;
    in_valid  = iv;
    out_ready = ordy;
    a         = W'($urandom_range(0, 15));
    b         = W'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
`ifdef LOGIC_OPCOUNT_EN
    exp_ops = 0;
`endif
    check_all();
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
`ifdef LOGIC_OPCOUNT_EN
    ops_clr = 1'b0; exp_ops = 0;
`endif
    @(posedge clk);
    do_reset(1'b0, 1'b0);

    // single OR
    cycle(1'b1, 4'd6, 4'd4, 2'b01, 1'b0);
    chk("or_6_4", 32'(o), 32'd6);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);

    // opcode sweep, results leave in push order
    cycle(1'b1, 4'd12, 4'd10, 2'b00, 1'b0);
    cycle(1'b1, 4'd12, 4'd10, 2'b01, 1'b0);
    cycle(1'b1, 4'd12, 4'd10, 2'b10, 1'b0);
    cycle(1'b1, 4'd12, 4'd10, 2'b11, 1'b0);
    chk("and_12_10", 32'(o), 32'd8);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
    chk("or_12_10", 32'(o), 32'd14);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
    chk("xor_12_10", 32'(o), 32'd6);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
    chk("nor_12_10", 32'(o), 32'd1);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
    cycle(1'b1, 4'd5, 4'd10, 2'b00, 1'b0);
    chk("and_zero_flag", 32'(zero), 32'd1);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);

    // fill, hold off the 5th, one pop, then the held entry goes in
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd(), rnd(), 2'($urandom_range(0, 3)), 1'b0);
    cycle(1'b1, 4'd9, 4'd3, 2'b10, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'd9, 4'd3, 2'b10, 1'b1);
    chk("after_pop_count", 32'(count), 32'd3);
    cycle(1'b1, 4'd9, 4'd3, 2'b10, 1'b0);
    chk("held_accepted_count", 32'(count), 32'd4);

    // simultaneous push/pop at count=2 across pointer wrap
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rnd(), rnd(), 2'($urandom_range(0, 3)), 1'b1);
      chk("pushpop_count", 32'(count), 32'd2);
    end

    // reset mid-operation with handshakes offered in the reset cycle
    cycle(1'b1, rnd(), rnd(), 2'($urandom_range(0, 3)), 1'b0);
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), rnd(), rnd(), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));

`ifdef LOGIC_OPCOUNT_EN
    do_reset(1'b0, 1'b0);
    cycle(1'b1, rnd(), rnd(), 2'b01, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, rnd(), rnd(), 2'($urandom_range(0, 3)), 1'b1);
    chk("ops_saturate", 32'(ops_done), 32'd255);
    cycle(1'b1, rnd(), rnd(), 2'b00, 1'b1, 1'b1);
    chk("ops_clr_priority", 32'(ops_done), 32'd0);
    cycle(1'b0, rnd(), rnd(), 2'b00, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
